// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//
// Shared constants and helpers for the board input conditioning stage.
//
// Contents:
//   N_IN_DEF         default number of input channels (I1..I5)
//   CLK_HZ_DEF       default system clock frequency in Hz (25 MHz, pin P3)
//   DEBOUNCE_MS_DEF  default required stable time in milliseconds
//   db_cycles()      converts a clock frequency and a stable time in ms into
//                    a stable time in clock cycles
//   cnt_width()      width of the per-channel stable counter for a given
//                    stable time in cycles (never less than 1 bit)
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int N_IN_DEF        = 5;
    localparam int CLK_HZ_DEF      = 25_000_000;
    localparam int DEBOUNCE_MS_DEF = 10;

    // Divide first so the intermediate product stays inside 32 bits for any
    // realistic clock frequency.
    function automatic int db_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // The counter only has to reach db-1, so $clog2(db) bits suffice.
    // A 1-bit floor keeps the vector legal for the smallest stable time.
    function automatic int cnt_width(input int db);
        return (db > 1) ? $clog2(db) : 1;
    endfunction

endpackage : btn_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//
// One input channel of the button conditioner: a 2-flop synchronizer, a
// stable-time counter, the debounced level, registered rise/fall pulses and a
// level that toggles on every press.
//
// Parameters:
//   DB_CYCLES  number of consecutive synchronized samples that must differ
//              from the current level before the level follows them
//              (legal range 2 .. 2^20-1)
//
// Ports:
//   clk     input   system clock
//   rst_n   input   asynchronous active-low reset
//   raw     input   raw pin level, asynchronous to clk
//   level   output  debounced level
//   rise    output  one-cycle pulse when level goes 0->1
//   fall    output  one-cycle pulse when level goes 1->0
//   toggle  output  flips on every rise
//
// Latency: with raw constant from the first sampling edge onward, level,
// rise/fall and toggle all change after edge DB_CYCLES+2 (two synchronizer
// edges plus DB_CYCLES counted samples). Every output is a flop; there is no
// combinational path from raw to any output.
// -----------------------------------------------------------------------------
module debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = db_cycles(CLK_HZ_DEF, DEBOUNCE_MS_DEF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          differs;
    logic          update;

    // s2 is the only consumer of the raw pin downstream of the synchronizer.
    assign differs = (s2 != level);

    // The level flips on the DB_CYCLES-th consecutive differing sample: the
    // counter has already seen DB_CYCLES-1 of them and this is one more.
    assign update  = differs && (cnt == CNT_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;

            // Any sample agreeing with the level discards the partial count,
            // so short glitches never add up. The counter stops at CNT_TERM
            // because reaching it with a differing sample always clears it.
            if (!differs) begin
                cnt <= '0;
            end else if (update) begin
                cnt   <= '0;
                level <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Pulses are registered alongside the level update so all outputs
            // move on the same edge. s2 is the new level when update is high.
            rise <= update &  s2;
            fall <= update & ~s2;

            if (update && s2) begin
                toggle <= ~toggle;
            end
        end
    end

endmodule : debounce_ch

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input conditioning stage for the active-high board inputs I1..I5
// (pins D1, C1, C2, E3, B4). Each channel is synchronized to clk, debounced
// with a stable-time counter and presented as a clean level, one-cycle
// rise/fall pulses and a press-toggled state. Channels share no state.
//
// Parameters:
//   N_IN         number of independent channels
//   CLK_HZ       clock frequency in Hz
//   DEBOUNCE_MS  required stable time in ms
//   DB_CYCLES    stable time in clock cycles (defaults to CLK_HZ/1000*DEBOUNCE_MS,
//                overridable, legal range 2 .. 2^20-1)
//
// Ports:
//   clk         input   system clock (25 MHz, pin P3)
//   rst_n       input   asynchronous active-low reset
//   btn_raw     input   raw pin levels, bit 0 = I1 .. bit 4 = I5, async to clk
//   btn_level   output  debounced level per channel
//   btn_rise    output  one-cycle pulse when btn_level goes 0->1
//   btn_fall    output  one-cycle pulse when btn_level goes 1->0
//   btn_toggle  output  flips on every btn_rise of that channel
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int DB_CYCLES   = db_cycles(CLK_HZ, DEBOUNCE_MS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] btn_raw,
    output logic [N_IN-1:0] btn_level,
    output logic [N_IN-1:0] btn_rise,
    output logic [N_IN-1:0] btn_fall,
    output logic [N_IN-1:0] btn_toggle
);

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i]),
            .toggle (btn_toggle[i])
        );
    end

endmodule : button_conditioner
